decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32 decode stage: one instruction per cycle from the fetch buffer to register read,
// with valid/ready on both sides, an optional two-entry skid buffer and an illegal counter.
module decode_stage #(
    parameter bit EN_M    = 1'b1,
    parameter bit EN_PRIV = 1'b1,
    parameter bit SKID    = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [31:0]      out_imm,
    output logic [3:0]       out_class,
    output logic [3:0]       out_op,
    output logic             out_wr_valid,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,
        CLS_LUI     = 4'd2,
        CLS_AUIPC   = 4'd3,
        CLS_JAL     = 4'd4,
        CLS_JALR    = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_LOAD    = 4'd7,
        CLS_STORE   = 4'd8,
        CLS_MULDIV  = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_SYSTEM  = 4'd11,
        CLS_CSR     = 4'd12,
        CLS_ILLEGAL = 4'd15
    } cls_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        cls_e        cls;
        logic [3:0]  op;
        logic        wr;
    } entry_t;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign rd    = in_instr[11:7];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'd0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    cls_e        d_cls;
    logic [3:0]  d_op;
    logic [31:0] d_imm;
    logic        bad;
    logic        priv;

    always_comb begin
        d_cls = CLS_ILLEGAL;
        d_op  = {1'b0, f3};
        d_imm = '0;
        bad   = 1'b0;
        priv  = 1'b0;
        case (opc)
            7'b0110011: begin
                case (f7)
                    7'h00: d_cls = CLS_ALU_R;
                    7'h20: begin
                        d_cls = CLS_ALU_R;
                        d_op  = {1'b1, f3};
                        bad   = !(f3 == 3'd0 || f3 == 3'd5);
                    end
                    7'h01: begin
                        d_cls = CLS_MULDIV;
                        bad   = !EN_M;
                    end
                    default: bad = 1'b1;
                endcase
            end
            7'b0010011: begin
                d_cls = CLS_ALU_I;
                d_imm = imm_i;
                // Shift-immediates carry a zero-extended shamt and keep funct7[5] in op
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    d_imm = {27'd0, in_instr[24:20]};
                    d_op  = {f7[5], f3};
                    bad   = !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
                end
            end
            7'b0110111: begin
                d_cls = CLS_LUI;
                d_imm = imm_u;
            end
            7'b0010111: begin
                d_cls = CLS_AUIPC;
                d_imm = imm_u;
            end
            7'b1101111: begin
                d_cls = CLS_JAL;
                d_imm = imm_j;
            end
            7'b1100111: begin
                d_cls = CLS_JALR;
                d_imm = imm_i;
                bad   = (f3 != 3'd0);
            end
            7'b1100011: begin
                d_cls = CLS_BRANCH;
                d_imm = imm_b;
                bad   = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'b0000011: begin
                d_cls = CLS_LOAD;
                d_imm = imm_i;
                bad   = (f3 == 3'd3 || f3 >= 3'd6);
            end
            7'b0100011: begin
                d_cls = CLS_STORE;
                d_imm = imm_s;
                bad   = (f3 >= 3'd3);
            end
            7'b0001111: d_cls = CLS_FENCE;
            7'b1110011: begin
                if (f3 == 3'd0) begin
                    d_cls = CLS_SYSTEM;
                    case (in_instr)
                        32'h0000_0073: d_op = 4'd0;
                        32'h0010_0073: d_op = 4'd1;
                        32'h3020_0073: begin d_op = 4'd2; priv = 1'b1; end
                        32'h1020_0073: begin d_op = 4'd3; priv = 1'b1; end
                        32'h1050_0073: begin d_op = 4'd4; priv = 1'b1; end
                        default: begin
                            d_op = 4'd5;
                            priv = 1'b1;
                            bad  = !(f7 == 7'h09 && rd == 5'd0);
                        end
                    endcase
                end else begin
                    d_cls = CLS_CSR;
                    d_imm = imm_i;
                    bad   = (f3 == 3'd4);
                end
            end
            default: bad = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11 || (priv && !EN_PRIV))
            bad = 1'b1;
    end

    entry_t dec;

    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        dec.instr = in_instr;
        dec.cls   = CLS_ILLEGAL;
        if (!bad) begin
            dec.cls = d_cls;
            dec.op  = d_op;
            dec.imm = d_imm;
            dec.wr  = (rd != 5'd0) && (d_cls inside {CLS_ALU_R, CLS_ALU_I, CLS_LUI, CLS_AUIPC,
                      CLS_JAL, CLS_JALR, CLS_LOAD, CLS_MULDIV, CLS_CSR});
        end
    end

    entry_t out_q, skid_q;
    logic   out_valid_q, skid_valid;
    logic   accept, out_xfer;

    assign in_ready = SKID ? !skid_valid : (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    // Output slot refills from the skid entry first so order is kept; new input goes to skid only while output stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
            illegal_cnt <= '0;
        end else begin
            if (out_xfer && !flush && out_q.cls == CLS_ILLEGAL && illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            if (flush) begin
                out_valid_q <= 1'b0;
                skid_valid  <= 1'b0;
            end else if (!out_valid_q || out_ready) begin
                if (skid_valid) begin
                    out_q       <= skid_q;
                    out_valid_q <= 1'b1;
                    skid_valid  <= 1'b0;
                end else begin
                    out_valid_q <= accept;
                    if (accept)
                        out_q <= dec;
                end
            end else if (accept) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_q.pc;
    assign out_instr    = out_q.instr;
    assign out_rd       = out_q.instr[11:7];
    assign out_rs1      = out_q.instr[19:15];
    assign out_rs2      = out_q.instr[24:20];
    assign out_imm      = out_q.imm;
    assign out_class    = out_q.cls;
    assign out_op       = out_q.op;
    assign out_wr_valid = out_q.wr;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a skid/CNT_W=4 instance and an EN_M=0/EN_PRIV=0/SKID=0 instance,
// both compared against a queue-based reference built from the RV32 decode rules.
module tb_decode_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [3:0]  cls;
        logic [3:0]  op;
        logic        wr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: full-featured with skid buffer and a 4-bit counter
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_wr_valid;
    logic [31:0] in_instr, in_pc, out_pc, out_instr, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_class, out_op, illegal_cnt;

    decode_stage #(.EN_M(1'b1), .EN_PRIV(1'b1), .SKID(1'b1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_class(out_class),
        .out_op(out_op), .out_wr_valid(out_wr_valid), .illegal_cnt(illegal_cnt)
    );

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_wr_valid;
    logic [31:0] b_in_instr, b_in_pc, b_out_pc, b_out_instr, b_out_imm;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    logic [3:0]  b_out_class, b_out_op;
    logic [15:0] b_illegal_cnt;

    decode_stage #(.EN_M(1'b0), .EN_PRIV(1'b0), .SKID(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pc(b_in_pc), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr), .out_rd(b_out_rd),
        .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_imm(b_out_imm), .out_class(b_out_class),
        .out_op(b_out_op), .out_wr_valid(b_out_wr_valid), .illegal_cnt(b_illegal_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;
    logic [31:0] pc_a = 32'h0000_1000;
    logic [31:0] pc_b = 32'h0000_8000;
    bit          last_acc;
    logic [6:0]  opc_tab [0:10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0f, 7'h73};
    logic [31:0] sys_tab [0:4]  = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h1020_0073, 32'h1050_0073};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the RV32 encoding rules
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                        input bit en_m, input bit en_priv);
        exp_t        e;
        int          opc, f3, f7, rd, cls, op;
        bit          ok, priv;
        logic [31:0] ii, is, ib, ij;
        opc  = int'(i[6:0]);
        f3   = int'(i[14:12]);
        f7   = int'(i[31:25]);
        rd   = int'(i[11:7]);
        ii   = 32'($signed(i) >>> 20);
        is   = (ii & ~32'h1F) | 32'(rd);
        ib   = (is & ~32'h801) | ((is & 32'h1) << 11);
        ij   = (ii & 32'hFFF0_07FE) | (i & 32'h000F_F000) | (32'(i[20]) << 11);
        ok   = (i[1:0] == 2'b11);
        priv = 1'b0;
        cls  = 15;
        op   = f3;
        e.imm = 32'd0;
        case (opc)
            'h33: if (f7 == 0) cls = 0;
                  else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) begin cls = 0; op = 8 + f3; end
                  else if (f7 == 1 && en_m) cls = 9;
                  else ok = 1'b0;
            'h13: begin
                cls = 1;
                e.imm = ii;
                if (f3 == 1 || f3 == 5) begin
                    e.imm = (i >> 20) & 32'd31;
                    if (f7 == 0) op = f3;
                    else if (f7 == 'h20 && f3 == 5) op = 8 + f3;
                    else ok = 1'b0;
                end
            end
            'h37: begin cls = 2; e.imm = i & 32'hFFFF_F000; end
            'h17: begin cls = 3; e.imm = i & 32'hFFFF_F000; end
            'h6f: begin cls = 4; e.imm = ij; end
            'h67: begin cls = 5; e.imm = ii; if (f3 != 0) ok = 1'b0; end
            'h63: begin cls = 6; e.imm = ib; if (f3 == 2 || f3 == 3) ok = 1'b0; end
            'h03: begin cls = 7; e.imm = ii; if (f3 == 3 || f3 >= 6) ok = 1'b0; end
            'h23: begin cls = 8; e.imm = is; if (f3 >= 3) ok = 1'b0; end
            'h0f: cls = 10;
            'h73: if (f3 == 0) begin
                      cls = 11;
                      if (i == 32'h0000_0073) op = 0;
                      else if (i == 32'h0010_0073) op = 1;
                      else if (i == 32'h3020_0073) begin op = 2; priv = 1'b1; end
                      else if (i == 32'h1020_0073) begin op = 3; priv = 1'b1; end
                      else if (i == 32'h1050_0073) begin op = 4; priv = 1'b1; end
                      else if ((i & 32'hFE00_7FFF) == 32'h1200_0073) begin op = 5; priv = 1'b1; end
                      else ok = 1'b0;
                  end else if (f3 == 4) ok = 1'b0;
                  else begin cls = 12; e.imm = ii; end
            default: ok = 1'b0;
        endcase
        if (priv && !en_priv) ok = 1'b0;
        if (!ok) begin
            cls   = 15;
            op    = 0;
            e.imm = 32'd0;
        end
        e.pc    = pc;
        e.instr = i;
        e.cls   = 4'(cls);
        e.op    = 4'(op);
        e.wr    = ok && (rd != 0) && (cls inside {0, 1, 2, 3, 4, 5, 7, 9, 12});
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel <= 10) begin
            r[6:0] = opc_tab[sel];
        end else if (sel == 11) begin
            r[6:0] = 7'h33;
            case ($urandom_range(0, 2))
                0:       r[31:25] = 7'h00;
                1:       r[31:25] = 7'h20;
                default: r[31:25] = 7'h01;
            endcase
        end else if (sel == 12) begin
            r = sys_tab[$urandom_range(0, 4)];
            if ($urandom_range(0, 2) == 0)
                r = {7'h09, 10'($urandom), 3'b000, 5'b00000, 7'h73};
        end else if (sel == 13) begin
            r[6:0]   = 7'h13;
            r[14:12] = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
            r[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        end else if (sel == 14) begin
            r = 32'd0;
        end
        return r;
    endfunction

    task automatic cmp_entry(input string tag, input exp_t e,
                             input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [3:0] cls, input logic [3:0] op, input logic wr);
        chk({tag, " out_pc"},       pc,        e.pc);
        chk({tag, " out_instr"},    instr,     e.instr);
        chk({tag, " out_imm"},      imm,       e.imm);
        chk({tag, " out_rd"},       32'(rd),   32'(e.instr[11:7]));
        chk({tag, " out_rs1"},      32'(rs1),  32'(e.instr[19:15]));
        chk({tag, " out_rs2"},      32'(rs2),  32'(e.instr[24:20]));
        chk({tag, " out_class"},    32'(cls),  32'(e.cls));
        chk({tag, " out_op"},       32'(op),   32'(e.op));
        chk({tag, " out_wr_valid"}, 32'(wr),   32'(e.wr));
    endtask

    task automatic check_output();
        chk("a in_ready",  32'(in_ready),  32'(qa.size() < 2));
        chk("a out_valid", 32'(out_valid), 32'(qa.size() > 0));
        if (qa.size() > 0)
            cmp_entry("a", qa[0], out_pc, out_instr, out_imm, out_rd, out_rs1, out_rs2,
                      out_class, out_op, out_wr_valid);
        chk("a illegal_cnt", 32'(illegal_cnt), cnt_a);
    endtask

    // One clock of instance A: drive, check, then advance the reference queue
    task automatic apply_stimulus(input bit v, input logic [31:0] instr, input bit ordy, input bit fl);
        bit   acc, xfer;
        exp_t e;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc_a;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_output();
        acc  = v && (qa.size() < 2);
        xfer = (qa.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            qa.delete();
        end else begin
            if (xfer) begin
                e = qa.pop_front();
                if (e.cls == 4'd15 && cnt_a < 15) cnt_a++;
            end
            if (acc) qa.push_back(ref_decode(instr, pc_a, 1'b1, 1'b1));
        end
        if (acc) pc_a += 32'd4;
        last_acc = acc;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic apply_b(input bit v, input logic [31:0] instr, input bit ordy);
        bit   acc, xfer;
        exp_t e;
        b_in_valid  = v;
        b_in_instr  = instr;
        b_in_pc     = pc_b;
        b_out_ready = ordy;
        #1;
        chk("b in_ready",  32'(b_in_ready),  32'(qb.size() == 0 || ordy));
        chk("b out_valid", 32'(b_out_valid), 32'(qb.size() > 0));
        if (qb.size() > 0)
            cmp_entry("b", qb[0], b_out_pc, b_out_instr, b_out_imm, b_out_rd, b_out_rs1, b_out_rs2,
                      b_out_class, b_out_op, b_out_wr_valid);
        chk("b illegal_cnt", 32'(b_illegal_cnt), cnt_b);
        acc  = v && (qb.size() == 0 || ordy);
        xfer = (qb.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (xfer) begin
            e = qb.pop_front();
            if (e.cls == 4'd15 && cnt_b < 65535) cnt_b++;
        end
        if (acc) begin
            qb.push_back(ref_decode(instr, pc_b, 1'b0, 1'b0));
            pc_b += 32'd4;
        end
        b_in_valid = 1'b0;
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge
    task automatic reset_check();
        rst_n = 1'b0;
        #1;
        chk("rst out_valid",    32'(out_valid),    32'd0);
        chk("rst out_pc",       out_pc,            32'd0);
        chk("rst out_instr",    out_instr,         32'd0);
        chk("rst out_imm",      out_imm,           32'd0);
        chk("rst out_class",    32'(out_class),    32'd0);
        chk("rst out_op",       32'(out_op),       32'd0);
        chk("rst out_rd",       32'(out_rd),       32'd0);
        chk("rst out_wr_valid", 32'(out_wr_valid), 32'd0);
        chk("rst illegal_cnt",  32'(illegal_cnt),  32'd0);
        chk("rst b_out_valid",  32'(b_out_valid),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.delete();
        qb.delete();
        cnt_a = 0;
        cnt_b = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] cur;
        int          n;
        rst_n = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0; b_flush = 1'b0; b_out_ready = 1'b0;
        #2;
        reset_check();

        apply_stimulus(1'b1, 32'hFFF1_0093, 1'b1, 1'b0);
        chk("addi out_valid", 32'(out_valid), 32'd1);
        chk("addi class",     32'(out_class), 32'd1);
        chk("addi op",        32'(out_op),    32'd0);
        chk("addi rd",        32'(out_rd),    32'd1);
        chk("addi rs1",       32'(out_rs1),   32'd2);
        chk("addi imm",       out_imm,        32'hFFFF_FFFF);
        chk("addi wr",        32'(out_wr_valid), 32'd1);
        apply_stimulus(1'b1, 32'h0220_81B3, 1'b1, 1'b0);
        chk("mul class", 32'(out_class), 32'd9);
        chk("mul op",    32'(out_op),    32'd0);
        chk("mul wr",    32'(out_wr_valid), 32'd1);
        apply_stimulus(1'b1, 32'hFFDF_F06F, 1'b1, 1'b0);
        chk("jal class", 32'(out_class), 32'd4);
        chk("jal imm",   out_imm,        32'hFFFF_FFFC);
        chk("jal wr",    32'(out_wr_valid), 32'd0);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);

        n   = 0;
        cur = rand_instr();
        for (int c = 1; c <= 30; c++) begin
            apply_stimulus(n < 6, cur, !(c >= 2 && c <= 4), 1'b0);
            if (last_acc) begin
                n++;
                cur = rand_instr();
            end
            if (n == 6 && qa.size() == 0) break;
        end
        chk("skid stream accepted", n, 32'd6);

        apply_stimulus(1'b1, 32'h0010_0113, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0020_0193, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0030_0213, 1'b0, 1'b1);
        chk("flush2 out_valid", 32'(out_valid), 32'd0);
        chk("flush2 in_ready",  32'(in_ready),  32'd1);
        apply_stimulus(1'b1, 32'h0040_0293, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0050_0313, 1'b0, 1'b1);
        chk("flush1 out_valid", 32'(out_valid), 32'd0);
        chk("flush1 in_ready",  32'(in_ready),  32'd1);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);

        reset_check();
        for (int k = 0; k < 18; k++)
            apply_stimulus(1'b1, 32'd0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
        chk("saturated illegal_cnt", 32'(illegal_cnt), 32'd15);
        apply_stimulus(1'b1, 32'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0);
        reset_check();

        apply_b(1'b1, 32'h0220_81B3, 1'b0);
        chk("b mul class", 32'(b_out_class), 32'd15);
        apply_b(1'b0, 32'd0, 1'b0);
        apply_b(1'b0, 32'd0, 1'b1);
        chk("b cnt after mul", 32'(b_illegal_cnt), 32'd1);
        apply_b(1'b1, 32'h3020_0073, 1'b1);
        chk("b mret class", 32'(b_out_class), 32'd15);
        apply_b(1'b1, 32'h0000_0073, 1'b1);
        chk("b ecall class", 32'(b_out_class), 32'd11);
        apply_b(1'b1, 32'hFFF1_0093, 1'b1);
        for (int k = 0; k < 60; k++)
            apply_b($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0);
        for (int k = 0; k < 3; k++)
            apply_b(1'b0, 32'd0, 1'b1);

        cur = rand_instr();
        for (int k = 0; k < 400; k++) begin
            apply_stimulus($urandom_range(0, 3) != 0, cur, $urandom_range(0, 3) != 0,
                           $urandom_range(0, 31) == 0);
            if (last_acc) cur = rand_instr();
        end
        for (int k = 0; k < 3; k++)
            apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
